ysyx_22040632_mem_arb: RTL and testbench

- Two-requester arbiter and burst sequencer directly upstream of the AXI read/write engine.
- Accepts burst requests from the instruction-fetch (IF, read-only) and load/store (LS, read/write) units, grants one at a time, and drives the engine's request side.
- Counts beats, generates w_last, routes read beats and write-data pulls to the owner, and returns a completion pulse.
- Owns rw_valid timing so the engine never re-launches a finished transaction.

---
 rtl/ysyx_22040632_mem_arb.sv | 146 ++++++++++++++
 tb/tb_ysyx_22040632_mem_arb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040632_mem_arb.sv
// Two-requester (IF read-only, LS read/write) arbiter and burst sequencer feeding the AXI engine.
// Latency: request seen in IDLE -> rw_valid the next cycle; done is combinational on rw_ready in WAIT.
// Backpressure: requesters hold req until done; beats advance only on engine r_hs / w_hs handshakes.
// Ports: clk/rst; IF request + read return; LS request + write-beat pull + read return;
//        engine request side (rw_*, w_strb, w_last) and engine handshakes (rw_ready, r_hs, w_hs, b_hs, data_read).
module ysyx_22040632_mem_arb #(
    parameter int STARVE_MAX = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic [7:0]          if_len,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_rvalid,
    output logic                if_done,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [7:0]          ls_len,
    input  logic [2:0]          ls_size,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    output logic                ls_wnext,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_rvalid,
    output logic                ls_done,
    output logic                rw_valid,
    output logic                rw_req,
    output logic [ADDR_W-1:0]   rw_addr,
    output logic [7:0]          rw_len,
    output logic [2:0]          rw_size,
    output logic [DATA_W-1:0]   rw_w_data,
    output logic [DATA_W/8-1:0] w_strb,
    output logic                w_last,
    input  logic                rw_ready,
    input  logic                r_hs,
    input  logic                w_hs,
    input  logic                b_hs,
    input  logic [DATA_W-1:0]   data_read
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY, WAIT} state_t;

    state_t        state, state_nxt;
    logic          owner_ls;     // 1 = LS owns the current transaction
    logic [7:0]    beat_cnt;
    logic [SW-1:0] starve_cnt;
    logic          rv_d;         // r_hs of the previous cycle; data_read is valid now
    logic          grant_ls, grant_if;
    logic          wr_busy, done;

    always_comb begin
        state_nxt = state;
        grant_ls  = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                // LS wins unless IF has been passed over STARVE_MAX times in a row
                if (ls_req && !(if_req && starve_cnt == SMAX)) begin
                    grant_ls  = 1'b1;
                    state_nxt = BUSY;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!rw_req) begin
                    if (r_hs && beat_cnt == rw_len) state_nxt = WAIT;
                end else if (b_hs) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (rw_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_ls   <= 1'b0;
            beat_cnt   <= '0;
            starve_cnt <= '0;
            rv_d       <= 1'b0;
            rw_valid   <= 1'b0;
            rw_req     <= 1'b0;
            rw_addr    <= '0;
            rw_len     <= '0;
            rw_size    <= '0;
        end else begin
            state <= state_nxt;
            // rw_valid is high exactly while in BUSY, so the engine never sees it
            // after the final handshake and cannot relaunch the transaction.
            rw_valid <= (state_nxt == BUSY);
            rv_d     <= (state == BUSY) && !rw_req && r_hs;
            if (grant_ls) begin
                owner_ls <= 1'b1;
                rw_req   <= ls_we;
                rw_addr  <= ls_addr;
                rw_len   <= ls_len;
                rw_size  <= ls_size;
                beat_cnt <= '0;
                if (!if_req)
                    starve_cnt <= '0;
                else if (starve_cnt != SMAX)
                    starve_cnt <= starve_cnt + SW'(1);
            end else if (grant_if) begin
                owner_ls   <= 1'b0;
                rw_req     <= 1'b0;
                rw_addr    <= if_addr;
                rw_len     <= if_len;
                rw_size    <= 3'b011;
                beat_cnt   <= '0;
                starve_cnt <= '0;
            end else if (state == BUSY && ((!rw_req && r_hs) || (rw_req && w_hs))
                         && beat_cnt != rw_len) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

    assign wr_busy   = (state == BUSY) && rw_req;
    assign rw_w_data = wr_busy ? ls_wdata : '0;
    assign w_strb    = wr_busy ? ls_wstrb : '0;
    assign w_last    = wr_busy && (beat_cnt == rw_len);
    assign ls_wnext  = wr_busy && w_hs;

    assign done    = (state == WAIT) && rw_ready;
    assign ls_done = done && owner_ls;
    assign if_done = done && !owner_ls;

    assign ls_rvalid = rv_d && owner_ls;
    assign if_rvalid = rv_d && !owner_ls;
    assign ls_rdata  = ls_rvalid ? data_read : '0;
    assign if_rdata  = if_rvalid ? data_read : '0;

endmodule

// File: tb/tb_ysyx_22040632_mem_arb.sv
// Directed bench for the IF/LS memory arbiter: reads, writes, arbitration, starvation and reset.
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
// The engine side is driven with fixed, hand-timed handshake sequences.
module tb_ysyx_22040632_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [7:0]  if_len;
    logic [63:0] if_rdata;
    logic        if_rvalid, if_done;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr;
    logic [7:0]  ls_len;
    logic [2:0]  ls_size;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wstrb;
    logic        ls_wnext;
    logic [63:0] ls_rdata;
    logic        ls_rvalid, ls_done;
    logic        rw_valid, rw_req;
    logic [31:0] rw_addr;
    logic [7:0]  rw_len;
    logic [2:0]  rw_size;
    logic [63:0] rw_w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        rw_ready, r_hs, w_hs, b_hs;
    logic [63:0] data_read;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_22040632_mem_arb #(.STARVE_MAX(2), .ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_len(if_len),
        .if_rdata(if_rdata), .if_rvalid(if_rvalid), .if_done(if_done),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_len(ls_len),
        .ls_size(ls_size), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
        .ls_wnext(ls_wnext), .ls_rdata(ls_rdata), .ls_rvalid(ls_rvalid), .ls_done(ls_done),
        .rw_valid(rw_valid), .rw_req(rw_req), .rw_addr(rw_addr), .rw_len(rw_len),
        .rw_size(rw_size), .rw_w_data(rw_w_data), .w_strb(w_strb), .w_last(w_last),
        .rw_ready(rw_ready), .r_hs(r_hs), .w_hs(w_hs), .b_hs(b_hs), .data_read(data_read)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; engine pulses default low each cycle.
    task automatic nxt();
        @(negedge clk);
        r_hs = 1'b0; w_hs = 1'b0; b_hs = 1'b0; rw_ready = 1'b0;
    endtask

    // One single-beat read, called on the falling edge after its grant.
    task automatic rd_txn(input string tag, input logic [31:0] exp_addr, input logic exp_ls,
                          input logic drop_if, input logic drop_ls);
        nxt(); r_hs = 1'b1; #1;
        chk({tag, "_vld"}, 64'(rw_valid), 64'd1);
        chk({tag, "_addr"}, 64'(rw_addr), 64'(exp_addr));
        nxt(); rw_ready = 1'b1; data_read = 64'hC0DE; #1;
        chk({tag, "_ls_done"}, 64'(ls_done), 64'(exp_ls));
        chk({tag, "_if_done"}, 64'(if_done), 64'(!exp_ls));
        chk({tag, "_rvalid"}, 64'(exp_ls ? ls_rvalid : if_rvalid), 64'd1);
        nxt(); if (drop_if) if_req = 1'b0; if (drop_ls) ls_req = 1'b0; #1;
        chk({tag, "_vld_idle"}, 64'(rw_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; if_len = 0;
        ls_req = 0; ls_we = 0; ls_addr = 0; ls_len = 0; ls_size = 0;
        ls_wdata = 0; ls_wstrb = 0; rw_ready = 0; r_hs = 0; w_hs = 0; b_hs = 0;
        data_read = 0;
        nxt(); nxt(); #1;
        chk("rst_vld", 64'(rw_valid), 64'd0);
        chk("rst_addr", 64'(rw_addr), 64'd0);
        chk("rst_done", 64'({if_done, ls_done, if_rvalid, ls_rvalid, ls_wnext, w_last}), 64'd0);

        // ---- IF 4-beat read ----
        nxt(); rst = 1'b0; if_req = 1'b1; if_addr = 32'h1000; if_len = 8'd3; #1;
        chk("if_vld_pre", 64'(rw_valid), 64'd0);
        nxt(); r_hs = 1'b1; #1;
        chk("if_vld", 64'(rw_valid), 64'd1);
        chk("if_req_bit", 64'(rw_req), 64'd0);
        chk("if_addr", 64'(rw_addr), 64'h1000);
        chk("if_len", 64'(rw_len), 64'd3);
        chk("if_size", 64'(rw_size), 64'd3);
        chk("if_rv0_pre", 64'(if_rvalid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            nxt(); r_hs = 1'b1; data_read = 64'hA0 + 64'(i); #1;
            chk("if_rvalid", 64'(if_rvalid), 64'd1);
            chk("if_rdata", if_rdata, 64'hA0 + 64'(i));
            chk("if_ls_rv", 64'(ls_rvalid), 64'd0);
            chk("if_vld_mid", 64'(rw_valid), 64'd1);
        end
        nxt(); rw_ready = 1'b1; data_read = 64'hA3; #1;
        chk("if_rvalid4", 64'(if_rvalid), 64'd1);
        chk("if_rdata4", if_rdata, 64'hA3);
        chk("if_vld_fall", 64'(rw_valid), 64'd0);
        chk("if_done", 64'(if_done), 64'd1);
        chk("if_ls_done", 64'(ls_done), 64'd0);
        nxt(); if_req = 1'b0; #1;
        chk("if_done_pulse", 64'(if_done), 64'd0);
        chk("if_rv_end", 64'(if_rvalid), 64'd0);

        // ---- LS 2-beat write ----
        nxt(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2000; ls_len = 8'd1; ls_size = 3'd3;
        ls_wdata = 64'h1111; ls_wstrb = 8'hFF; #1;
        nxt(); #1;
        chk("wr_vld", 64'(rw_valid), 64'd1);
        chk("wr_req", 64'(rw_req), 64'd1);
        chk("wr_addr", 64'(rw_addr), 64'h2000);
        chk("wr_wnext_idle", 64'(ls_wnext), 64'd0);
        nxt(); w_hs = 1'b1; #1;
        chk("wr_wnext0", 64'(ls_wnext), 64'd1);
        chk("wr_last0", 64'(w_last), 64'd0);
        chk("wr_data0", rw_w_data, 64'h1111);
        chk("wr_strb0", 64'(w_strb), 64'hFF);
        nxt(); w_hs = 1'b1; ls_wdata = 64'h2222; ls_wstrb = 8'h0F; #1;
        chk("wr_wnext1", 64'(ls_wnext), 64'd1);
        chk("wr_last1", 64'(w_last), 64'd1);
        chk("wr_data1", rw_w_data, 64'h2222);
        chk("wr_strb1", 64'(w_strb), 64'h0F);
        nxt(); b_hs = 1'b1; #1;
        chk("wr_vld_b", 64'(rw_valid), 64'd1);
        chk("wr_wnext_b", 64'(ls_wnext), 64'd0);
        nxt(); rw_ready = 1'b1; #1;
        chk("wr_vld_fall", 64'(rw_valid), 64'd0);
        chk("wr_ls_done", 64'(ls_done), 64'd1);
        chk("wr_if_done", 64'(if_done), 64'd0);
        nxt(); ls_req = 1'b0; ls_we = 1'b0; r_hs = 1'b1; w_hs = 1'b1; #1;
        chk("wr_done_pulse", 64'(ls_done), 64'd0);
        chk("idle_wnext", 64'(ls_wnext), 64'd0);
        nxt(); #1;
        chk("no_relaunch", 64'(rw_valid), 64'd0);
        chk("idle_rhs_ign", 64'({if_rvalid, ls_rvalid}), 64'd0);

        // ---- simultaneous requests: LS first (len 0), address change after grant ----
        nxt(); if_req = 1'b1; if_addr = 32'h3000; if_len = 8'd0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h4000; ls_len = 8'd0; ls_size = 3'd2; #1;
        nxt(); ls_addr = 32'hDEAD; r_hs = 1'b1; #1;
        chk("both_ls_first", 64'(rw_addr), 64'h4000);
        chk("both_ls_size", 64'(rw_size), 64'd2);
        chk("both_ls_rd", 64'(rw_req), 64'd0);
        nxt(); rw_ready = 1'b1; data_read = 64'hBEEF; #1;
        chk("len0_rvalid", 64'(ls_rvalid), 64'd1);
        chk("len0_rdata", ls_rdata, 64'hBEEF);
        chk("len0_if_rv", 64'(if_rvalid), 64'd0);
        chk("len0_vld_fall", 64'(rw_valid), 64'd0);
        chk("addr_immune", 64'(rw_addr), 64'h4000);
        chk("len0_done", 64'(ls_done), 64'd1);
        nxt(); ls_req = 1'b0; #1;
        chk("len0_single", 64'(ls_rvalid), 64'd0);
        rd_txn("both_if", 32'h3000, 1'b0, 1'b1, 1'b0);

        // ---- starvation: IF held, LS re-requesting ----
        nxt(); if_req = 1'b1; if_addr = 32'h5000; ls_req = 1'b1; ls_addr = 32'h6000; #1;
        rd_txn("st1", 32'h6000, 1'b1, 1'b0, 1'b0);
        rd_txn("st2", 32'h6000, 1'b1, 1'b0, 1'b0);
        rd_txn("st3", 32'h5000, 1'b0, 1'b1, 1'b0);
        rd_txn("st4", 32'h6000, 1'b1, 1'b0, 1'b1);

        // ---- reset mid-burst, then a fresh request ----
        nxt(); if_req = 1'b1; if_addr = 32'h7000; if_len = 8'd3; #1;
        nxt(); r_hs = 1'b1; #1;
        nxt(); r_hs = 1'b1; data_read = 64'h77; #1;
        nxt(); rst = 1'b1; data_read = 64'h78; #1;
        chk("mid_rvalid", 64'(if_rvalid), 64'd1);
        nxt(); rst = 1'b0; if_req = 1'b0; #1;
        chk("rst_mid_vld", 64'(rw_valid), 64'd0);
        chk("rst_mid_addr", 64'(rw_addr), 64'd0);
        chk("rst_mid_len", 64'(rw_len), 64'd0);
        chk("rst_mid_rv", 64'({if_rvalid, if_rdata != 64'd0, if_done, rw_size}), 64'd0);
        nxt(); if_req = 1'b1; if_addr = 32'h8000; if_len = 8'd1; #1;
        chk("fresh_vld_pre", 64'(rw_valid), 64'd0);
        nxt(); r_hs = 1'b1; #1;
        chk("fresh_addr", 64'(rw_addr), 64'h8000);
        chk("fresh_vld", 64'(rw_valid), 64'd1);
        nxt(); r_hs = 1'b1; data_read = 64'h80; #1;
        chk("fresh_rv0", 64'(if_rvalid), 64'd1);
        nxt(); rw_ready = 1'b1; data_read = 64'h81; #1;
        chk("fresh_rdata1", if_rdata, 64'h81);
        chk("fresh_done", 64'(if_done), 64'd1);
        nxt(); if_req = 1'b0; #1;
        chk("fresh_idle", 64'(rw_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
